// File: rtl/aes_decrypt_seq.sv
// aes_decrypt_seq: iterative AES inverse cipher for 128/192/256-bit keys.
// The key is expanded once, one schedule word per cycle, and kept for any
// number of blocks. Each block takes one cycle per round. The S-box helpers
// compute the GF(2^8) inverse arithmetically, so no lookup tables are needed.
module aes_decrypt_seq #(
   parameter int N  = 128,
   parameter int NR = 10,
   parameter int NK = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           key_valid,
   output logic           key_ready,
   input  logic [N-1:0]   key_in,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [127:0]   cipher_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [127:0]   plain_out,
   output logic           busy
);

   localparam int NW = 4 * (NR + 1);
   localparam int IW = $clog2(NW);
   localparam logic [IW-1:0] LAST_WORD = IW'(NW - 1);
   localparam logic [IW-1:0] NK_W      = IW'(NK);
   localparam logic [2:0]    NK_LAST   = 3'(NK - 1);
   localparam logic [3:0]    NR_W      = 4'(NR);

   // The NOKEY state doubles as the "no valid key" status.
   typedef enum logic [2:0] {NOKEY, KEYEXP, READY, ROUND, DONE} stateT;

   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Inverse computed as a^254 (maps 0 to 0, as AES requires).
   function automatic logic [7:0] gfInv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] res;
      sq  = a;
      res = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gfMul(sq, sq);
         res = gfMul(res, sq);
      end
      return res;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
      return (b << k) | (b >> (8 - k));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gfInv(a);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] invSbox(input logic [7:0] a);
      return gfInv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Byte k of the state sits at bits 127-8k; row = k%4, column = k/4.
   function automatic logic [127:0] invShiftRows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] invSubBytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int k = 0; k < 16; k++) begin
         o[127 - 8*k -: 8] = invSbox(s[127 - 8*k -: 8]);
      end
      return o;
   endfunction

   function automatic logic [127:0] invMixColumns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0;
      logic [7:0]   a1;
      logic [7:0]   a2;
      logic [7:0]   a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
         o[119 - 32*c -: 8] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
         o[111 - 32*c -: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
         o[103 - 32*c -: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
      end
      return o;
   endfunction

   stateT          r_state;
   stateT          w_nextState;
   logic [31:0]    r_w [0:NW-1];
   logic [IW-1:0]  r_wIdx;
   logic [2:0]     r_kIdx;
   logic [7:0]     r_rcon;
   logic [3:0]     r_round;
   logic [127:0]   r_data;
   logic [127:0]   r_plain;

   logic           w_keyFire;
   logic           w_blockFire;
   logic [31:0]    w_prevWord;
   logic [31:0]    w_oldWord;
   logic [31:0]    w_temp;
   logic [31:0]    w_newWord;
   logic [3:0]     w_rkSel;
   logic [IW-1:0]  w_rkIdx;
   logic [127:0]   w_roundKey;
   logic [127:0]   w_added;
   logic [127:0]   w_roundOut;

   assign w_keyFire   = key_valid && key_ready;
   assign w_blockFire = in_valid && in_ready;
   assign plain_out   = r_plain;

   // Next-state and handshake decode; a pending key masks in_ready so the key wins.
   always_comb begin
      w_nextState = r_state;
      key_ready   = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         NOKEY: begin
            key_ready = 1'b1;
            if (key_valid) w_nextState = KEYEXP;
         end
         KEYEXP: begin
            busy = 1'b1;
            if (r_wIdx == LAST_WORD) w_nextState = READY;
         end
         READY: begin
            key_ready = 1'b1;
            in_ready  = !key_valid;
            if (key_valid)     w_nextState = KEYEXP;
            else if (in_valid) w_nextState = ROUND;
         end
         ROUND: begin
            busy = 1'b1;
            if (r_round == 4'd0) w_nextState = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_nextState = READY;
         end
         default: w_nextState = NOKEY;
      endcase
   end

   // Next schedule word: RotWord/SubWord/Rcon at the start of each key-length group,
   // and the extra SubWord halfway through a group for 256-bit keys.
   always_comb begin
      w_prevWord = r_w[r_wIdx - IW'(1)];
      w_oldWord  = r_w[r_wIdx - NK_W];
      w_temp     = w_prevWord;
      if (r_kIdx == 3'd0) begin
         w_temp = subWord({w_prevWord[23:0], w_prevWord[31:24]}) ^ {r_rcon, 24'h000000};
      end else if (NK > 6 && r_kIdx == 3'd4) begin
         w_temp = subWord(w_prevWord);
      end
      w_newWord = w_oldWord ^ w_temp;
   end

   // Round key select (key NR for the initial whitening) and one inverse round.
   always_comb begin
      w_rkSel    = (r_state == ROUND) ? r_round : NR_W;
      w_rkIdx    = IW'({w_rkSel, 2'b00});
      w_roundKey = {r_w[w_rkIdx], r_w[w_rkIdx + IW'(1)], r_w[w_rkIdx + IW'(2)], r_w[w_rkIdx + IW'(3)]};
      w_added    = invSubBytes(invShiftRows(r_data)) ^ w_roundKey;
      w_roundOut = (r_round != 4'd0) ? invMixColumns(w_added) : w_added;
   end

   // Control state, round counter and result register, cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= NOKEY;
         r_round <= 4'd0;
         r_plain <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_blockFire) begin
            r_round <= NR_W - 4'd1;
         end else if (r_state == ROUND && r_round != 4'd0) begin
            r_round <= r_round - 4'd1;
         end
         if (r_state == ROUND && r_round == 4'd0) begin
            r_plain <= w_roundOut;
         end
      end
   end

   // Key schedule storage and the working state; always loaded before use, so no reset.
   always_ff @(posedge clk) begin
      if (w_keyFire) begin
         for (int j = 0; j < NK; j++) begin
            r_w[j] <= key_in[N - 1 - 32*j -: 32];
         end
         r_wIdx <= NK_W;
         r_kIdx <= 3'd0;
         r_rcon <= 8'h01;
      end else if (r_state == KEYEXP) begin
         r_w[r_wIdx] <= w_newWord;
         r_wIdx      <= r_wIdx + IW'(1);
         r_kIdx      <= (r_kIdx == NK_LAST) ? 3'd0 : r_kIdx + 3'd1;
         if (r_kIdx == 3'd0) r_rcon <= gfMul(r_rcon, 8'h02);
      end
      if (w_blockFire) begin
         r_data <= cipher_in ^ w_roundKey;
      end else if (r_state == ROUND) begin
         r_data <= w_roundOut;
      end
   end

endmodule

// File: tb/tb_aes_decrypt_seq.sv
// tb_aes_decrypt_seq: directed FIPS-197 vectors against 128/192/256-bit instances.
module tb_aes_decrypt_seq;

   localparam logic [127:0] PLAIN = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] C256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] K128  = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
   localparam logic [255:0] K192  = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
   localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   logic              clk;
   logic              reset;
   logic [2:0]        keyValid;
   logic [2:0]        keyReady;
   logic [127:0]      keyIn128;
   logic [191:0]      keyIn192;
   logic [255:0]      keyIn256;
   logic [2:0]        inValid;
   logic [2:0]        inReady;
   logic [2:0][127:0] cipherIn;
   logic [2:0]        outValid;
   logic [2:0]        outReady;
   logic [2:0][127:0] plainOut;
   logic [2:0]        busy;

   int checks   = 0;
   int failures = 0;

   aes_decrypt_seq #(.N(128), .NR(10), .NK(4)) u128 (
      .clk(clk), .reset(reset),
      .key_valid(keyValid[0]), .key_ready(keyReady[0]), .key_in(keyIn128),
      .in_valid(inValid[0]), .in_ready(inReady[0]), .cipher_in(cipherIn[0]),
      .out_valid(outValid[0]), .out_ready(outReady[0]), .plain_out(plainOut[0]),
      .busy(busy[0])
   );

   aes_decrypt_seq #(.N(192), .NR(12), .NK(6)) u192 (
      .clk(clk), .reset(reset),
      .key_valid(keyValid[1]), .key_ready(keyReady[1]), .key_in(keyIn192),
      .in_valid(inValid[1]), .in_ready(inReady[1]), .cipher_in(cipherIn[1]),
      .out_valid(outValid[1]), .out_ready(outReady[1]), .plain_out(plainOut[1]),
      .busy(busy[1])
   );

   aes_decrypt_seq #(.N(256), .NR(14), .NK(8)) u256 (
      .clk(clk), .reset(reset),
      .key_valid(keyValid[2]), .key_ready(keyReady[2]), .key_in(keyIn256),
      .in_valid(inValid[2]), .in_ready(inReady[2]), .cipher_in(cipherIn[2]),
      .out_valid(outValid[2]), .out_ready(outReady[2]), .plain_out(plainOut[2]),
      .busy(busy[2])
   );

   // 100 MHz free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so a stuck handshake can never hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic loadKey(input int sel, input logic [255:0] key, input int expCycles, input string tag);
      int cnt;
      @(negedge clk);
      checkOutput({tag, "_keyReady"}, 128'(keyReady[sel]), 128'(1));
      case (sel)
         0:       keyIn128 = key[255:128];
         1:       keyIn192 = key[255:64];
         default: keyIn256 = key;
      endcase
      keyValid[sel] = 1'b1;
      @(negedge clk);
      keyValid[sel] = 1'b0;
      cnt = 0;
      while (busy[sel] && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      checkOutput({tag, "_keyexpCycles"}, 128'(cnt), 128'(expCycles));
   endtask

   task automatic applyStimulus(input int sel, input logic [127:0] cipher, input logic [127:0] expPlain,
                                input int nr, input int hold, input string tag);
      int   cnt;
      logic stable;
      @(negedge clk);
      checkOutput({tag, "_inReady"}, 128'(inReady[sel]), 128'(1));
      cipherIn[sel] = cipher;
      outReady[sel] = 1'b0;
      inValid[sel]  = 1'b1;
      @(negedge clk);
      inValid[sel] = 1'b0;
      cnt = 0;
      while (!outValid[sel] && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput({tag, "_latency"}, 128'(cnt), 128'(nr));
      checkOutput({tag, "_plain"}, plainOut[sel], expPlain);
      checkOutput({tag, "_doneInReady"}, 128'(inReady[sel]), 128'(0));
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!outValid[sel] || plainOut[sel] !== expPlain || inReady[sel]) stable = 1'b0;
      end
      if (hold > 0) checkOutput({tag, "_holdStable"}, 128'(stable), 128'(1));
      outReady[sel] = 1'b1;
      @(negedge clk);
      outReady[sel] = 1'b0;
      checkOutput({tag, "_postValid"}, 128'(outValid[sel]), 128'(0));
      checkOutput({tag, "_postPlain"}, plainOut[sel], expPlain);
      checkOutput({tag, "_postInReady"}, 128'(inReady[sel]), 128'(1));
   endtask

   // Directed sequence: reset, all three key sizes, back-pressure, priority, mid-block reset.
   initial begin
      int   cnt;
      logic sawIn;
      logic sawValid;
      logic sawBusy;
      reset    = 1'b1;
      keyValid = '0;
      inValid  = '0;
      outReady = '0;
      keyIn128 = '0;
      keyIn192 = '0;
      keyIn256 = '0;
      cipherIn = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("rst_keyReady", 128'(keyReady[0]), 128'(1));
      checkOutput("rst_inReady", 128'(inReady[0]), 128'(0));
      checkOutput("rst_outValid", 128'(outValid[0]), 128'(0));
      checkOutput("rst_busy", 128'(busy[0]), 128'(0));
      checkOutput("rst_plain", plainOut[0], 128'(0));

      loadKey(0, K128, 40, "k128");
      applyStimulus(0, C128, PLAIN, 10, 5, "blk1");
      applyStimulus(0, C128, PLAIN, 10, 0, "blk2");

      $display("[TB] key and block offered together in READY");
      @(negedge clk);
      keyIn128    = 128'h000102030405060708090a0b0c0d0e0f;
      cipherIn[0] = C128;
      keyValid[0] = 1'b1;
      inValid[0]  = 1'b1;
      #1;
      checkOutput("prio_inReady", 128'(inReady[0]), 128'(0));
      checkOutput("prio_keyReady", 128'(keyReady[0]), 128'(1));
      @(negedge clk);
      keyValid[0] = 1'b0;
      cnt   = 0;
      sawIn = 1'b0;
      while (busy[0] && cnt < 200) begin
         cnt++;
         if (inReady[0]) sawIn = 1'b1;
         @(negedge clk);
      end
      inValid[0] = 1'b0;
      checkOutput("prio_busyCycles", 128'(cnt), 128'(40));
      checkOutput("prio_keyexpInReady", 128'(sawIn), 128'(0));
      applyStimulus(0, C128, PLAIN, 10, 0, "blk3");

      $display("[TB] reset in the middle of a block");
      @(negedge clk);
      cipherIn[0] = C128;
      inValid[0]  = 1'b1;
      @(negedge clk);
      inValid[0] = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("rstmid_busyBefore", 128'(busy[0]), 128'(1));
      #1 reset = 1'b1;
      #2 reset = 1'b0;
      sawValid   = 1'b0;
      sawBusy    = 1'b0;
      sawIn      = 1'b0;
      inValid[0] = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (outValid[0]) sawValid = 1'b1;
         if (busy[0])     sawBusy  = 1'b1;
         if (inReady[0])  sawIn    = 1'b1;
      end
      inValid[0] = 1'b0;
      checkOutput("rstmid_outValid", 128'(sawValid), 128'(0));
      checkOutput("rstmid_nokeyBusy", 128'(sawBusy), 128'(0));
      checkOutput("rstmid_nokeyInReady", 128'(sawIn), 128'(0));
      checkOutput("rstmid_keyReady", 128'(keyReady[0]), 128'(1));
      loadKey(0, K128, 40, "k128b");
      applyStimulus(0, C128, PLAIN, 10, 0, "blk4");

      loadKey(1, K192, 46, "k192");
      applyStimulus(1, C192, PLAIN, 12, 0, "blk192");
      loadKey(2, K256, 52, "k256");
      applyStimulus(2, C256, PLAIN, 14, 2, "blk256");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_decrypt_seq.md
AES_DECRYPT_SEQ -- requirements
Module: aes_decrypt_seq

Interface
REQ-001 SHALL have parameter N, default 128, meaning key length in bits (128/192/256).
REQ-002 SHALL have parameter NR, default 10, meaning number of rounds (10/12/14).
REQ-003 SHALL have parameter NK, default 4, meaning key length in 32-bit words (4/6/8).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port key_valid  input  1  meaning key_in is valid.
REQ-007 SHALL have port key_ready  output  1  meaning the block accepts a key this cycle.
REQ-008 SHALL have port key_in  input  N  meaning the cipher key; bits N-1:N-32 are word w[0].
REQ-009 SHALL have port in_valid  input  1  meaning cipher_in is valid.
REQ-010 SHALL have port in_ready  output  1  meaning the block accepts a ciphertext block this cycle.
REQ-011 SHALL have port cipher_in  input  128  meaning the ciphertext block; bits 127:120 are state byte 0, in column-major order.
REQ-012 SHALL have port out_valid  output  1  meaning plain_out holds a result.
REQ-013 SHALL have port out_ready  input  1  meaning the sink accepts plain_out.
REQ-014 SHALL have port plain_out  output  128  meaning the decrypted block, in the same byte order as cipher_in.
REQ-015 SHALL have port busy  output  1  meaning the state is KEYEXP or ROUND.

Function
REQ-016 SHALL implement the FSM states NOKEY, KEYEXP, READY, ROUND and DONE.
REQ-017 SHALL set key_ready = 1 only in NOKEY and READY.
REQ-018 SHALL set in_ready = 1 only in READY with key_valid = 0, so a key has priority over a block in the same cycle.
REQ-019 SHALL, on key handshake (key_valid && key_ready), load w[0..NK-1] from key_in and enter KEYEXP.
REQ-020 SHALL, in KEYEXP, compute one FIPS-197 expansion word per cycle for w[NK]..w[4*NR+3], including the extra SubWord for NK=8 when i mod 8 = 4.
REQ-021 SHALL spend exactly 4*(NR+1)-NK cycles in KEYEXP (40/46/52 cycles), then go to READY.
REQ-022 SHALL ignore key_valid and in_valid while in KEYEXP.
REQ-023 SHALL, on block handshake, load state = cipher_in XOR round key NR, set round counter r = NR-1, and enter ROUND.
REQ-024 SHALL, in each ROUND cycle, apply InvShiftRows, InvSubBytes and AddRoundKey(r), then InvMixColumns only when r != 0, and decrement r.
REQ-025 SHALL go from ROUND to DONE after the r = 0 cycle, and assert out_valid exactly NR cycles after the accepting edge.
REQ-026 SHALL, in DONE, hold out_valid = 1 with plain_out stable until out_ready = 1, then go to READY on that edge.
REQ-027 SHALL deassert out_valid in the cycle after the output handshake and keep plain_out at its last value.
REQ-028 SHALL keep in_ready = 0 in DONE, with no overlap of an input and an output handshake.
REQ-029 SHALL retain the expanded key across blocks; a new key handshake in READY overwrites it and returns the block to KEYEXP.
REQ-030 SHALL reuse the team's existing S-box and inverse S-box functions.

Reset
REQ-031 SHALL, on reset asserted (asynchronous, any state), go to NOKEY.
REQ-032 SHALL, on reset, clear out_valid, busy, plain_out, the state register, r and the key-valid status.
REQ-033 SHALL, after reset, present key_ready = 1 and in_ready = 0.
REQ-034 SHALL, on reset during KEYEXP or ROUND, abandon the operation with no out_valid pulse, and require a fresh key before any block is accepted.

Verification
REQ-035 SHALL verify: N=128, key 000102030405060708090a0b0c0d0e0f, wait 40 cycles, cipher 69c4e0d86a7b0430d8cdb78070b4c55a -> out_valid 10 cycles after accept, plain_out 00112233445566778899aabbccddeeff.
REQ-036 SHALL verify: N=192/NR=12/NK=6, key 000102...1617, cipher dda97ca4864cdfe06eaf70a0ec0d7191 -> plain 00112233445566778899aabbccddeeff after 12 cycles; N=256/NR=14/NK=8, key 000102...1e1f, cipher 8ea2b7ca516745bfeafc49904b496089 -> same plain after 14 cycles.
REQ-037 SHALL verify: out_ready held 0 for 5 cycles in DONE -> out_valid and plain_out stable, in_ready = 0; out_ready = 1 -> READY next cycle; a second block then decrypts correctly without reloading the key.
REQ-038 SHALL verify: key_valid and in_valid both high in READY -> key accepted, block not accepted (in_ready = 0), busy = 1 for 40 cycles.
REQ-039 SHALL verify: reset pulsed at round 5 -> out_valid never asserts, key_ready = 1, in_ready = 0 until a new key has been expanded.
REQ-040 SHALL verify: in_valid in NOKEY or KEYEXP -> no acceptance, state unchanged.
